// File: rtl/crc16_checker_if.sv
// rtl/crc16_checker_if.sv - serial frame input and parallel result bus for crc16_checker (err_count exists only with CRC16_CHK_ERRCNT_EN)
interface crc16_checker_if #(
  parameter int DATA_BITS = 34
) ();
  logic                 start;
  logic                 bit_valid;
  logic                 data_in;
  logic [15:0]          crc_out;
  logic [DATA_BITS-1:0] data_out;
  logic                 busy;
  logic                 frame_done;
  logic                 crc_ok;
  logic                 crc_err;
`ifdef CRC16_CHK_ERRCNT_EN
  logic [7:0]           err_count;

  modport master (
    output start, bit_valid, data_in,
    input  crc_out, data_out, busy, frame_done, crc_ok, crc_err, err_count
  );
  modport slave (
    input  start, bit_valid, data_in,
    output crc_out, data_out, busy, frame_done, crc_ok, crc_err, err_count
  );
`else
  modport master (
    output start, bit_valid, data_in,
    input  crc_out, data_out, busy, frame_done, crc_ok, crc_err
  );
  modport slave (
    input  start, bit_valid, data_in,
    output crc_out, data_out, busy, frame_done, crc_ok, crc_err
  );
`endif
endinterface

// File: rtl/crc16_checker.sv
// rtl/crc16_checker.sv - serial CRC-16 frame checker; CRC16_CHK_ERRCNT_EN adds a saturating bad-frame counter
module crc16_checker #(
  parameter int          DATA_BITS = 34,
  parameter logic [15:0] POLY      = 16'h8005
) (
  input logic            clk,
  input logic            reset,
  crc16_checker_if.slave bus
);
  localparam int            CW        = $clog2(DATA_BITS + 16) + 1;
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_CRC  = CW'(DATA_BITS + 15);

  typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} state_t;

  state_t               state_q, state_d;
  logic [15:0]          crc_q, crc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] payload_q, payload_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 crc_ok_q, crc_ok_d;
  logic                 crc_err_q, crc_err_d;
`ifdef CRC16_CHK_ERRCNT_EN
  logic [7:0]           err_count_q, err_count_d;
`endif

  function automatic logic [15:0] lfsr_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? POLY : 16'h0000);
  endfunction

  logic                 new_frame;
  logic [15:0]          crc_next;
  logic [DATA_BITS-1:0] payload_shift;

  assign new_frame     = bus.start & bus.bit_valid;
  assign crc_next      = lfsr_step(crc_q, bus.data_in);
  assign payload_shift = DATA_BITS'({payload_q, bus.data_in});

  // Next-state logic: a qualified start always wins and restarts the frame from bit 0
  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    payload_d  = payload_q;
    data_out_d = data_out_q;
    crc_ok_d   = crc_ok_q;
    crc_err_d  = crc_err_q;
`ifdef CRC16_CHK_ERRCNT_EN
    err_count_d = err_count_q;
`endif
    if (new_frame) begin
      state_d   = (DATA_BITS == 1) ? CRC : DATA;
      crc_d     = lfsr_step(16'h0000, bus.data_in);
      cnt_d     = CW'(1);
      payload_d = DATA_BITS'(bus.data_in);
      crc_ok_d  = 1'b0;
      crc_err_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        DATA: begin
          if (bus.bit_valid) begin
            crc_d     = crc_next;
            payload_d = payload_shift;
            cnt_d     = cnt_q + CW'(1);
            if (cnt_q == LAST_DATA) state_d = CRC;
          end
        end
        CRC: begin
          if (bus.bit_valid) begin
            crc_d = crc_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_CRC) begin
              // Results are latched with the last bit so they are visible during DONE
              state_d    = DONE;
              data_out_d = payload_q;
              crc_ok_d   = (crc_next == 16'h0000);
              crc_err_d  = (crc_next != 16'h0000);
`ifdef CRC16_CHK_ERRCNT_EN
              if (crc_next != 16'h0000 && err_count_q != 8'hFF)
                err_count_d = err_count_q + 8'd1;
`endif
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      crc_q      <= 16'h0000;
      cnt_q      <= '0;
      payload_q  <= '0;
      data_out_q <= '0;
      crc_ok_q   <= 1'b0;
      crc_err_q  <= 1'b0;
`ifdef CRC16_CHK_ERRCNT_EN
      err_count_q <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      payload_q  <= payload_d;
      data_out_q <= data_out_d;
      crc_ok_q   <= crc_ok_d;
      crc_err_q  <= crc_err_d;
`ifdef CRC16_CHK_ERRCNT_EN
      err_count_q <= err_count_d;
`endif
    end
  end

  assign bus.crc_out    = crc_q;
  assign bus.data_out   = data_out_q;
  assign bus.busy       = (state_q == DATA) || (state_q == CRC);
  assign bus.frame_done = (state_q == DONE);
  assign bus.crc_ok     = crc_ok_q;
  assign bus.crc_err    = crc_err_q;
`ifdef CRC16_CHK_ERRCNT_EN
  assign bus.err_count  = err_count_q;
`endif
endmodule

// File: tb/tb_crc16_checker.sv
// tb/tb_crc16_checker.sv - scoreboard bench for crc16_checker with a polynomial-division reference model
module tb_crc16_checker;
  localparam int          DATA_BITS = 34;
  localparam logic [15:0] POLY      = 16'h8005;

  typedef bit bitq_t[$];
  typedef struct {
    logic [DATA_BITS-1:0] data;
    logic                 ok;
    logic [15:0]          rem;
    int                   done_cyc;
    logic [7:0]           ecnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  crc16_checker_if #(.DATA_BITS(DATA_BITS)) bus ();
  crc16_checker #(.DATA_BITS(DATA_BITS), .POLY(POLY)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         pushed = 0;
  int         seen = 0;
  logic [7:0] ecnt_m = 8'h00;
  exp_t       sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Remainder of msg(x) * x^16 divided by the generator, by textbook long division
  function automatic logic [15:0] poly_rem(input bitq_t msg);
    bit          r[$];
    logic [16:0] g;
    logic [15:0] rem;
    g = {1'b1, POLY};
    r = msg;
    repeat (16) r.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (r[i])
        for (int k = 0; k <= 16; k++) r[i+k] = r[i+k] ^ g[16-k];
    for (int k = 0; k < 16; k++) rem[15-k] = r[msg.size()+k];
    return rem;
  endfunction

  function automatic bitq_t make_frame(input logic [DATA_BITS-1:0] p);
    bitq_t       q;
    logic [15:0] c;
    for (int i = DATA_BITS - 1; i >= 0; i--) q.push_back(p[i]);
    c = poly_rem(q);
    for (int i = 15; i >= 0; i--) q.push_back(c[i]);
    return q;
  endfunction

  task automatic push_exp(input bitq_t fb);
    exp_t e;
    e.rem = poly_rem(fb);
    for (int i = 0; i < DATA_BITS; i++) e.data[DATA_BITS-1-i] = fb[i];
    e.ok = (e.rem == 16'h0000);
    e.done_cyc = cyc + 1;
    if (!e.ok && ecnt_m != 8'hFF) ecnt_m = ecnt_m + 8'd1;
    e.ecnt = ecnt_m;
    sb.push_back(e);
    pushed++;
  endtask

  // Drives the first n bits of fb; gaps carry random start with bit_valid low
  task automatic send(input bitq_t fb, input int n, input int gap_pct, input bit lead_gap);
    for (int i = 0; i < n; i++) begin
      if (lead_gap || (i > 0 && $urandom_range(99) < gap_pct)) begin
        @(posedge clk); #1;
        bus.bit_valid = 1'b0;
        bus.start = 1'($urandom);
        bus.data_in = 1'($urandom);
      end
      @(posedge clk); #1;
      bus.start = (i == 0);
      bus.bit_valid = 1'b1;
      bus.data_in = fb[i];
    end
    if (n == fb.size()) push_exp(fb);
  endtask

  task automatic idle(input int n);
    logic v;
    repeat (n) begin
      @(posedge clk); #1;
      v = 1'($urandom);
      bus.bit_valid = v;
      bus.start = v ? 1'b0 : 1'($urandom);
      bus.data_in = 1'($urandom);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_crc_out", 64'(bus.crc_out), 64'h0);
    chk("rst_data_out", 64'(bus.data_out), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_frame_done", 64'(bus.frame_done), 64'h0);
    chk("rst_crc_ok", 64'(bus.crc_ok), 64'h0);
    chk("rst_crc_err", 64'(bus.crc_err), 64'h0);
`ifdef CRC16_CHK_ERRCNT_EN
    chk("rst_err_count", 64'(bus.err_count), 64'h0);
`endif
  endtask

  // Monitor: every frame_done pulse is matched against the oldest expected frame
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.frame_done === 1'b1) begin
      seen++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
        chk("data_out", 64'(bus.data_out), 64'(e.data));
        chk("crc_ok", 64'(bus.crc_ok), 64'(e.ok));
        chk("crc_err", 64'(bus.crc_err), 64'(!e.ok));
        chk("crc_out", 64'(bus.crc_out), 64'(e.rem));
`ifdef CRC16_CHK_ERRCNT_EN
        chk("err_count", 64'(bus.err_count), 64'(e.ecnt));
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bitq_t                fb, fb2;
    logic [DATA_BITS-1:0] p;
    int                   j;

    bus.start = 1'b0;
    bus.bit_valid = 1'b0;
    bus.data_in = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_state();

    // All-zero frame, continuous
    fb = {};
    repeat (DATA_BITS + 16) fb.push_back(1'b0);
    send(fb, fb.size(), 0, 1'b0);
    idle(3);
    chk("zero_ok_held", 64'(bus.crc_ok), 64'h1);
    chk("zero_busy_after", 64'(bus.busy), 64'h0);

    // Payload 1 with its generator CRC, continuous
    fb = make_frame(34'd1);
    send(fb, fb.size(), 0, 1'b0);
    idle(2);

    // Alternating payload, one payload bit corrupted in flight
    fb = make_frame(34'h2_AAAA_AAAA);
    fb[5] = ~fb[5];
    send(fb, fb.size(), 0, 1'b0);
    idle(3);
    chk("err_held", 64'(bus.crc_err), 64'h1);
    chk("err_ok_low", 64'(bus.crc_ok), 64'h0);

    // Abort at bit 20 then a full good frame; new start clears held flags
    p = {$urandom, $urandom};
    fb = make_frame(p);
    send(fb, 20, 0, 1'b0);
    @(negedge clk);
    chk("start_clears_err", 64'(bus.crc_err), 64'h0);
    chk("busy_in_frame", 64'(bus.busy), 64'h1);
    p = {$urandom, $urandom};
    fb2 = make_frame(p);
    send(fb2, fb2.size(), 0, 1'b0);

    // Stalled frame: an idle cycle before every bit
    fb = make_frame(34'd1);
    send(fb, fb.size(), 0, 1'b1);
    idle(2);

    // Abort inside the CRC field, then restart
    p = {$urandom, $urandom};
    fb = make_frame(p);
    send(fb, 40, 0, 1'b0);
    p = {$urandom, $urandom};
    fb = make_frame(p);
    send(fb, fb.size(), 20, 1'b0);

    // Reset at bit 40 of a frame, then a good frame
    p = {$urandom, $urandom};
    fb = make_frame(p);
    send(fb, 40, 0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.bit_valid = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    ecnt_m = 8'h00;
    chk_reset_state();
    p = {$urandom, $urandom};
    fb = make_frame(p);
    send(fb, fb.size(), 0, 1'b0);

    // Random frames, back-to-back or spaced, with gaps, errors and aborts
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(3) == 0) begin
        p = {$urandom, $urandom};
        fb = make_frame(p);
        send(fb, $urandom_range(DATA_BITS + 15, 1), 25, 1'b0);
      end
      p = {$urandom, $urandom};
      fb = make_frame(p);
      if ($urandom_range(1) == 1) begin
        j = $urandom_range(fb.size() - 1);
        fb[j] = ~fb[j];
      end
      send(fb, fb.size(), ($urandom_range(1) == 1) ? 30 : 0, 1'b0);
      idle($urandom_range(2));
    end

    idle(5);
    for (int w = 0; w < 200 && sb.size() != 0; w++) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    chk("frame_done_count", 64'(seen), 64'(pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/crc16_checker.md
# crc16_checker

Serial CRC-16 receiver/checker, the receive-side counterpart of the `crc16` serial generator. It accepts a bit-serial frame of `DATA_BITS` payload bits followed by the 16-bit CRC, MSB first. It runs the same LFSR over all `DATA_BITS+16` bits and declares the frame good when the final remainder is zero. The recovered payload is presented in parallel at end of frame, for the downstream frame consumer.

## Interface
- `DATA_BITS`, 34, payload length in bits (≥1).
- `POLY`, 16'h8005, generator polynomial (x^16 implicit); must match the transmitter.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  qualifies the current `data_in` as bit 0 of a new frame (sampled only with `bit_valid`).
- `bit_valid`  in  1  `data_in` carries a valid bit this cycle.
- `data_in`  in  1  serial frame bit, MSB first.
- `crc_out`  out  16  running LFSR remainder.
- `data_out`  out  DATA_BITS  payload captured from the last completed frame.
- `busy`  out  1  frame in progress (state DATA or CRC).
- `frame_done`  out  1  one-cycle pulse when a frame completes.
- `crc_ok`  out  1  last completed frame had remainder 0; held until the next `start`.
- `crc_err`  out  1  last completed frame had nonzero remainder; held until the next `start`.
- `err_count`  out  8  saturating count of bad frames (present only with `CRC16_CHK_ERRCNT_EN`).

## Operation
- LFSR update on every accepted bit: `fb = crc[15] ^ data_in`; `crc <= {crc[14:0],1'b0} ^ (fb ? POLY : 16'h0000)`. Initial value is 16'h0000.
- States:
  - IDLE: `bit_valid & start` loads the LFSR as if from 0 with the first bit, sets bit counter = 1, shifts the bit into the payload shift register, and goes to DATA. When `DATA_BITS==1`, it goes straight to CRC.
  - DATA: each accepted bit updates the LFSR and payload shift register, and increments the counter. Acceptance of bit `DATA_BITS-1` goes to CRC.
  - CRC: accepted bits update the LFSR only. Acceptance of the 16th CRC bit goes to DONE, latching the remainder check.
  - DONE (one cycle): `frame_done=1`, `data_out` <= payload register, and `crc_ok`/`crc_err` set from the final remainder. Next state is IDLE.
- `bit_valid=0` in DATA/CRC stalls: no LFSR, counter or payload change.
- `start & bit_valid` in DATA, CRC or DONE aborts the current frame. No `frame_done` is produced, `data_out` is unchanged, and a new frame starts with this bit as bit 0. `start` without `bit_valid` is ignored.
- `start` in IDLE clears `crc_ok`/`crc_err`.
- Counter width is `$clog2(DATA_BITS+16)+1`; it wraps only via reset or frame restart.

## Timing
- Bit k is accepted at the rising edge where `bit_valid=1`. `crc_out` reflects all accepted bits one cycle later.
- `frame_done`, `crc_ok`/`crc_err` and `data_out` update one cycle after the last CRC bit is accepted. Latency is `DATA_BITS+16+1` cycles for back-to-back valid bits.
- In DONE, a `start & bit_valid` bit begins the next frame with no dead cycle (abort rule; `frame_done` still pulses this cycle).
- Reset, including mid-frame: state IDLE, `crc_out=0`, `data_out=0`, `busy=0`, `frame_done=0`, `crc_ok=0`, `crc_err=0`, `err_count=0`, counter 0.

## Configuration
- `CRC16_CHK_ERRCNT_EN` defined: `err_count` port exists. It increments on each DONE with nonzero remainder, saturates at 8'hFF, and clears only on reset.
- Not defined: no `err_count` port and no counter logic. All other behaviour is identical.

## Test plan
- Good zero frame: reset, then `start` with 50 valid bits, all 0 (payload 0, CRC 16'h0000). Expect `frame_done` at cycle 51, `crc_ok=1`, `crc_err=0`, `data_out=0`.
- Good nonzero frame: payload 34'd1, CRC 16'h8005, continuous valid. Expect `crc_ok=1`, `data_out=34'd1`, `crc_out=0` at done.
- Corrupted frame: payload 34'b1010…10 with CRC from the `crc16` generator, one payload bit flipped. Expect `crc_err=1`, `crc_ok=0`, `err_count=1` when the macro is defined.
- Stalled frame: the 34'd1/8005 frame with `bit_valid` deasserted every other cycle. Same result as continuous, `frame_done` at cycle 101.
- Abort/restart: `start` reasserted at bit 20, then a full good frame follows. Exactly one `frame_done`, `crc_ok=1`, `data_out` from the second frame.
- Reset mid-frame at bit 40: all outputs zero next cycle, no `frame_done`. A following good frame passes.
